// File: rtl/sum_accumulator.sv
// Frame accumulator for adder sums: adds N_SAMPLES unsigned beats into a saturating
// total and hands the result, beat count and sticky overflow flag to a valid/ready consumer.
module sum_accumulator #(
  parameter int IN_W      = 9,
  parameter int ACC_W     = 16,
  parameter int N_SAMPLES = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(N_SAMPLES);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             ovf;
  logic [ACC_W:0]   sum_wide;
  logic [7:0]       count_inc;
  logic             accept;
  logic             handoff;
  logic             frame_end;

  // One extra bit of headroom so a carry out of the accumulator is visible.
  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                             input logic [IN_W-1:0]  d);
    return {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, d};
  endfunction

  function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign sum_wide  = add_ext(acc, in_data);
  assign count_inc = count + 8'd1;
  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;
  assign frame_end = accept & (count_inc == LAST_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else if (state == ACCUM) begin
      if (frame_end) state_nxt = HOLD;
    end else begin
      if (out_ready) state_nxt = ACCUM;
    end
  end

  // in_ready depends only on state and clear, so no in_valid -> out_* path exists.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (state == ACCUM) begin
      in_ready = ~clear;
    end else begin
      out_valid = 1'b1;
    end
  end

  // Frame datapath: an abort or a completed handoff starts a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear || handoff) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= saturate(sum_wide);
      count <= count_inc;
      ovf   <= ovf | sum_wide[ACC_W];
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign overflow  = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (N=25, 200, 1) driven by a frame table and
// hand sequences; completed results are checked against a per-instance expectation queue.
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        c25, v25, rdy25, r25, ov25, f25;
  logic [8:0]  d25;
  logic [15:0] s25;
  logic [7:0]  n25;

  logic        c200, v200, rdy200, r200, ov200, f200;
  logic [8:0]  d200;
  logic [15:0] s200;
  logic [7:0]  n200;

  logic        c1, v1, rdy1, r1, ov1, f1;
  logic [8:0]  d1;
  logic [15:0] s1;
  logic [7:0]  n1;

  sum_accumulator #(.IN_W(9), .ACC_W(16), .N_SAMPLES(25)) dut25 (
    .clk(clk), .rst(rst), .clear(c25), .in_valid(v25), .in_ready(rdy25), .in_data(d25),
    .out_valid(ov25), .out_ready(r25), .out_sum(s25), .out_count(n25), .overflow(f25));

  sum_accumulator #(.IN_W(9), .ACC_W(16), .N_SAMPLES(200)) dut200 (
    .clk(clk), .rst(rst), .clear(c200), .in_valid(v200), .in_ready(rdy200), .in_data(d200),
    .out_valid(ov200), .out_ready(r200), .out_sum(s200), .out_count(n200), .overflow(f200));

  sum_accumulator #(.IN_W(9), .ACC_W(16), .N_SAMPLES(1)) dut1 (
    .clk(clk), .rst(rst), .clear(c1), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(r1), .out_sum(s1), .out_count(n1), .overflow(f1));

  typedef struct packed {
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [8:0]  base;
    logic [8:0]  step;
    bit          randv;
    logic [15:0] exp;
  } vec_t;

  res_t q25[$];
  res_t q200[$];
  res_t q1[$];
  vec_t tbl[6];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Result monitors: a handshake only completes when clear is low.
  always @(negedge clk) begin
    res_t e;
    if (!rst && ov25 && r25 && !c25) begin
      if (q25.size() == 0) begin
        checks++; errors++;
        $display("FAIL res25 unexpected result sum %0h", s25);
      end else begin
        e = q25.pop_front();
        chk("res25_sum", 32'(s25), 32'(e.sum));
        chk("res25_cnt", 32'(n25), 32'(e.cnt));
        chk("res25_ovf", 32'(f25), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst && ov200 && r200 && !c200) begin
      if (q200.size() == 0) begin
        checks++; errors++;
        $display("FAIL res200 unexpected result sum %0h", s200);
      end else begin
        e = q200.pop_front();
        chk("res200_sum", 32'(s200), 32'(e.sum));
        chk("res200_cnt", 32'(n200), 32'(e.cnt));
        chk("res200_ovf", 32'(f200), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst && ov1 && r1 && !c1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL res1 unexpected result sum %0h", s1);
      end else begin
        e = q1.pop_front();
        chk("res1_sum", 32'(s1), 32'(e.sum));
        chk("res1_cnt", 32'(n1), 32'(e.cnt));
        chk("res1_ovf", 32'(f1), 32'(e.ovf));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat25(input logic [8:0] d);
    int  g = 0;
    bit  a = 1'b0;
    while (!a && g < 20) begin
      v25 = 1'b1; d25 = d;
      @(negedge clk);
      a = rdy25;
      @(posedge clk); #1;
      v25 = 1'b0;
      g++;
    end
    if (!a) begin
      checks++; errors++;
      $display("FAIL beat25 timeout got no accept want accept");
    end
  endtask

  task automatic beat200(input logic [8:0] d);
    int  g = 0;
    bit  a = 1'b0;
    while (!a && g < 20) begin
      v200 = 1'b1; d200 = d;
      @(negedge clk);
      a = rdy200;
      @(posedge clk); #1;
      v200 = 1'b0;
      g++;
    end
    if (!a) begin
      checks++; errors++;
      $display("FAIL beat200 timeout got no accept want accept");
    end
  endtask

  // Full 25-beat frame with data base+step*i; optionally random gaps in in_valid.
  task automatic frame25(input logic [8:0] base, input logic [8:0] step, input bit randv,
                         input bit push, input logic [15:0] exp);
    int i = 0;
    int guard = 0;
    bit v;
    bit a;
    if (push) q25.push_back('{exp, 8'd25, 1'b0});
    while (i < 25 && guard < 400) begin
      v = randv ? ($urandom_range(0, 1) == 1) : 1'b1;
      v25 = v;
      d25 = base + step * 9'(i);
      @(negedge clk);
      a = v && rdy25;
      if (a && i == 24) chk("lat_pre", 32'(ov25), 32'd0);
      @(posedge clk); #1;
      v25 = 1'b0;
      if (a) begin
        i++;
        if (i == 25) chk("lat_post", 32'(ov25), 32'd1);
      end
      guard++;
    end
    if (i < 25) begin
      checks++; errors++;
      $display("FAIL frame25 timeout got %0d beats want 25", i);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    bit a;

    tbl[0] = '{9'd0,     9'd2, 1'b0, 16'h0258};
    tbl[1] = '{9'd0,     9'd2, 1'b1, 16'h0258};
    tbl[2] = '{9'd1,     9'd0, 1'b0, 16'h0019};
    tbl[3] = '{9'h1FF,   9'd0, 1'b1, 16'h31E7};
    tbl[4] = '{9'd3,     9'd3, 1'b0, 16'h03CF};
    tbl[5] = '{9'h100,   9'd1, 1'b1, 16'h1A2C};

    rst = 1'b1;
    c25 = 0; v25 = 0; d25 = 0; r25 = 1;
    c200 = 0; v200 = 0; d200 = 0; r200 = 1;
    c1 = 0; v1 = 0; d1 = 0; r1 = 1;

    #1;
    chk("rst_ov25", 32'(ov25), 0);
    chk("rst_s25", 32'(s25), 0);
    chk("rst_n25", 32'(n25), 0);
    chk("rst_f25", 32'(f25), 0);
    chk("rst_ov200", 32'(ov200), 0);
    chk("rst_ov1", 32'(ov1), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy25_after_rst", 32'(rdy25), 1);
    chk("rdy1_after_rst", 32'(rdy1), 1);

    // Table-driven frames
    for (int k = 0; k < 6; k++) begin
      frame25(tbl[k].base, tbl[k].step, tbl[k].randv, 1'b1, tbl[k].exp);
    end
    wait_cycles(2);
    chk("q25_drained_tbl", 32'(q25.size()), 0);

    // Output backpressure: result held, extra beats refused
    r25 = 1'b0;
    frame25(9'd5, 9'd0, 1'b0, 1'b1, 16'h007D);
    for (int k = 0; k < 10; k++) begin
      v25 = 1'b1; d25 = 9'h055;
      @(negedge clk);
      chk("bp_valid", 32'(ov25), 1);
      chk("bp_rdy", 32'(rdy25), 0);
      chk("bp_sum", 32'(s25), 32'h7D);
      chk("bp_cnt", 32'(n25), 25);
      @(posedge clk); #1;
    end
    v25 = 1'b0; r25 = 1'b1;
    wait_cycles(1);
    chk("handoff_ov", 32'(ov25), 0);
    chk("handoff_sum", 32'(s25), 0);
    chk("handoff_cnt", 32'(n25), 0);
    chk("handoff_rdy", 32'(rdy25), 1);

    // Clear mid-frame with a beat presented
    for (int k = 0; k < 10; k++) beat25(9'h010);
    chk("pre_clr_sum", 32'(s25), 32'hA0);
    chk("pre_clr_cnt", 32'(n25), 10);
    c25 = 1'b1; v25 = 1'b1; d25 = 9'h010;
    @(negedge clk);
    chk("clr_rdy", 32'(rdy25), 0);
    @(posedge clk); #1;
    c25 = 1'b0; v25 = 1'b0;
    chk("clr_sum", 32'(s25), 0);
    chk("clr_cnt", 32'(n25), 0);
    q25.push_back('{16'h0019, 8'd25, 1'b0});
    for (int k = 0; k < 25; k++) beat25(9'h001);
    wait_cycles(2);

    // Clear in HOLD together with out_ready drops the result
    r25 = 1'b0;
    frame25(9'd1, 9'd0, 1'b0, 1'b0, 16'h0);
    c25 = 1'b1; r25 = 1'b1;
    @(posedge clk); #1;
    c25 = 1'b0;
    chk("clr_hold_ov", 32'(ov25), 0);
    chk("clr_hold_sum", 32'(s25), 0);
    chk("clr_hold_cnt", 32'(n25), 0);
    wait_cycles(2);

    // Async reset mid-frame, then in HOLD
    for (int k = 0; k < 7; k++) beat25(9'd4);
    chk("pre_rst_cnt", 32'(n25), 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", 32'(s25), 0);
    chk("arst_cnt", 32'(n25), 0);
    chk("arst_ov", 32'(ov25), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    frame25(9'd0, 9'd2, 1'b0, 1'b1, 16'h0258);
    wait_cycles(2);
    r25 = 1'b0;
    frame25(9'd7, 9'd0, 1'b0, 1'b0, 16'h0);
    chk("hold_before_rst", 32'(ov25), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hold_ov", 32'(ov25), 0);
    chk("arst_hold_sum", 32'(s25), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    r25 = 1'b1;
    wait_cycles(1);

    // Saturation on the 200-beat instance, then a clean zero frame
    q200.push_back('{16'hFFFF, 8'd200, 1'b1});
    for (int k = 0; k < 200; k++) begin
      beat200(9'h1FF);
      if (k == 127) chk("sat_ovf_128", 32'(f200), 0);
      if (k == 128) chk("sat_ovf_129", 32'(f200), 1);
    end
    wait_cycles(2);
    chk("sat_next_ovf", 32'(f200), 0);
    q200.push_back('{16'h0000, 8'd200, 1'b0});
    for (int k = 0; k < 200; k++) beat200(9'h000);
    wait_cycles(2);

    // N_SAMPLES=1 alternation
    d = 9'd1;
    v1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d1 = d;
      @(negedge clk);
      chk("n1_rdy", 32'(rdy1), (k % 2 == 0) ? 32'd1 : 32'd0);
      a = rdy1;
      if (a) q1.push_back('{16'(d), 8'd1, 1'b0});
      @(posedge clk); #1;
      if (a) d = d + 9'd1;
    end
    v1 = 1'b0;
    wait_cycles(3);

    chk("q25_empty", 32'(q25.size()), 0);
    chk("q200_empty", 32'(q200.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
